// File: rtl/pb_event_gen.sv
// ---------------------------------------------------------------------------
// pb_event_gen
//   Multi-channel push-button front end. Each channel synchronises a raw
//   button level, debounces it with a stable-time filter and turns the
//   debounced level into press/release pulses. A per-channel hold FSM
//   raises long_press after a sustained press and, when enabled, emits
//   auto-repeat pulses while the button stays held.
//
// Ports
//   clk_100       in   1     system clock, rising edge
//   rst           in   1     synchronous active-high reset
//   pb_raw        in   N_CH  asynchronous raw button levels (1 = pressed)
//   repeat_en     in   N_CH  per-channel auto-repeat enable
//   pb_level      out  N_CH  debounced level (registered)
//   press_pulse   out  N_CH  one-cycle pulse on debounced 0->1
//   release_pulse out  N_CH  one-cycle pulse on debounced 1->0
//   long_press    out  N_CH  high while held beyond HOLD_CYCLES
//   repeat_pulse  out  N_CH  one-cycle auto-repeat pulse
//
// Handshake: there is none; every output is a plain registered level or a
// single-cycle strobe valid in the cycle it is high. Consumers need no
// ready signal and must sample every cycle.
//
// Each channel's hold FSM state is kept in g_ch[i].state for observation.
// ---------------------------------------------------------------------------
module pb_event_gen #(
    parameter int N_CH          = 4,
    parameter int DEB_CYCLES    = 20,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int CNT_W         = 27
) (
    input  logic            clk_100,
    input  logic            rst,
    input  logic [N_CH-1:0] pb_raw,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] pb_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_pulse
);

    localparam logic [1:0] ST_RELEASED  = 2'd0;
    localparam logic [1:0] ST_HELD      = 2'd1;
    localparam logic [1:0] ST_REPEATING = 2'd2;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             s1;
        logic             s2;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             long_q;
        logic             repeat_q;
        logic [CNT_W-1:0] dcnt;
        logic [CNT_W-1:0] hcnt;
        logic [CNT_W-1:0] rcnt;
        logic [1:0]       state;
        logic             flip;

        // The filter commits in this edge: s2 has differed from the
        // debounced level for DEB_CYCLES consecutive edges.
        assign flip = (s2 != level_q) && (dcnt == DEB_LAST);

        always_ff @(posedge clk_100) begin
            if (rst) begin
                s1        <= 1'b0;
                s2        <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
                dcnt      <= '0;
                hcnt      <= '0;
                rcnt      <= '0;
                state     <= ST_RELEASED;
            end else begin
                s1 <= pb_raw[i];
                s2 <= s1;

                // Debounce: any agreement with the current level restarts
                // the count, so short glitches never reach pb_level.
                if (s2 != level_q) begin
                    if (dcnt == DEB_LAST) begin
                        level_q <= s2;
                        dcnt    <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end else begin
                    dcnt <= '0;
                end

                press_q   <= flip & s2;
                release_q <= flip & ~s2;
                repeat_q  <= 1'b0;

                // Release is checked first so it beats a hold expiry
                // landing on the same edge.
                if (flip && !s2) begin
                    state  <= ST_RELEASED;
                    hcnt   <= '0;
                    rcnt   <= '0;
                    long_q <= 1'b0;
                end else begin
                    case (state)
                        ST_RELEASED: begin
                            hcnt <= '0;
                            rcnt <= '0;
                            if (flip && s2) begin
                                state <= ST_HELD;
                            end
                        end
                        ST_HELD: begin
                            if (hcnt == HOLD_LAST) begin
                                state    <= ST_REPEATING;
                                long_q   <= 1'b1;
                                repeat_q <= repeat_en[i];
                                rcnt     <= '0;
                            end else begin
                                hcnt <= hcnt + 1'b1;
                            end
                        end
                        ST_REPEATING: begin
                            // rcnt keeps running while repeat_en is low so
                            // re-enabling stays on the original grid.
                            if (rcnt == REP_LAST) begin
                                rcnt     <= '0;
                                repeat_q <= repeat_en[i];
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end
                        default: begin
                            state  <= ST_RELEASED;
                            long_q <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign pb_level[i]      = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_press[i]    = long_q;
        assign repeat_pulse[i]  = repeat_q;
    end

endmodule

// File: tb/tb_pb_event_gen.sv
// ---------------------------------------------------------------------------
// tb_pb_event_gen
//   Scoreboard bench for pb_event_gen. A reference process evaluates the
//   button rules at every rising edge and pushes the expected outputs into
//   exp_q; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_pb_event_gen;

    localparam int N_CH   = 2;
    localparam int DEB    = 4;
    localparam int HOLD   = 10;
    localparam int REP    = 3;
    localparam int CNT_W  = 8;
    localparam int EW     = 5 * N_CH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N_CH-1:0] pb_raw    = '0;
    logic [N_CH-1:0] repeat_en = '0;
    logic [N_CH-1:0] pb_level;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] long_press;
    logic [N_CH-1:0] repeat_pulse;

    pb_event_gen #(
        .N_CH(N_CH), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .CNT_W(CNT_W)
    ) dut (
        .clk_100(clk), .rst(rst), .pb_raw(pb_raw), .repeat_en(repeat_en),
        .pb_level(pb_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .long_press(long_press),
        .repeat_pulse(repeat_pulse)
    );

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // Sync: raw value sampled two edges earlier (zeros after reset).
    // Debounce: pb_level flips once the last DEB synced samples taken since
    // the previous flip all differ from it. Hold behaviour follows from the
    // age of the current press in cycles.
    logic [N_CH-1:0] m_s1, m_s2, m_lvl;
    int              press_t[N_CH];
    bit              win[N_CH][$];
    int              t = 0;

    task automatic model_step();
        logic [N_CH-1:0] e_pp, e_rp, e_lp, e_rep;
        e_pp = '0; e_rp = '0; e_lp = '0; e_rep = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rst) begin
                m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_lvl[c] = 1'b0;
                win[c].delete();
                press_t[c] = -1;
            end else begin
                bit s2in;
                bit flip;
                int age;
                s2in    = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = pb_raw[c];
                win[c].push_back(s2in);
                if (win[c].size() > DEB) void'(win[c].pop_front());
                flip = (win[c].size() == DEB);
                foreach (win[c][k]) if (win[c][k] == m_lvl[c]) flip = 0;
                if (flip) begin
                    m_lvl[c] = ~m_lvl[c];
                    win[c].delete();
                    if (m_lvl[c]) begin e_pp[c] = 1'b1; press_t[c] = t; end
                    else begin e_rp[c] = 1'b1; press_t[c] = -1; end
                end
                if (m_lvl[c] && press_t[c] >= 0) begin
                    age = t - press_t[c];
                    if (age >= HOLD) begin
                        e_lp[c]  = 1'b1;
                        e_rep[c] = repeat_en[c] && ((age - HOLD) % REP == 0);
                    end
                end
            end
        end
        exp_q.push_back({m_lvl, e_pp, e_rp, e_lp, e_rep});
        t++;
    endtask

    initial begin
        for (int c = 0; c < N_CH; c++) press_t[c] = -1;
        m_s1 = '0; m_s2 = '0; m_lvl = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- scoreboard monitor ----------------
    task automatic check(input string name, input logic [N_CH-1:0] act,
                         input logic [N_CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b expected=%b", name, t, act, exp);
        end
    endtask

    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pb_level",      pb_level,      e[5*N_CH-1:4*N_CH]);
                check("press_pulse",   press_pulse,   e[4*N_CH-1:3*N_CH]);
                check("release_pulse", release_pulse, e[3*N_CH-1:2*N_CH]);
                check("long_press",    long_press,    e[2*N_CH-1:N_CH]);
                check("repeat_pulse",  repeat_pulse,  e[N_CH-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N_CH-1:0] raw, input logic [N_CH-1:0] en,
                         input int n);
        pb_raw    = raw;
        repeat_en = en;
        tick(n);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int run[N_CH];
        tick(3);
        rst = 1'b0;
        tick(2);

        // clean press on channel 0, then release
        drive(2'b01, 2'b00, 20);
        drive(2'b00, 2'b00, 12);

        // glitches: 3-cycle high rejected, then a 4-cycle high accepted
        drive(2'b01, 2'b00, 3);
        drive(2'b00, 2'b00, 10);
        drive(2'b01, 2'b00, 4);
        drive(2'b00, 2'b00, 12);

        // long press with repeat, then release
        drive(2'b01, 2'b01, 36);
        drive(2'b00, 2'b01, 12);

        // repeat_en gating during REPEATING
        drive(2'b01, 2'b01, 20);
        drive(2'b01, 2'b00, 7);
        drive(2'b01, 2'b01, 12);
        drive(2'b00, 2'b00, 12);

        // both channels pressed together; channel 1 released mid-hold
        drive(2'b11, 2'b11, 12);
        drive(2'b01, 2'b11, 25);
        drive(2'b00, 2'b00, 12);

        // release landing exactly on hold expiry: 10-cycle press window
        drive(2'b01, 2'b01, 10);
        drive(2'b00, 2'b01, 14);

        // reset while long_press is high and the button stays held
        drive(2'b01, 2'b01, 22);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(30);
        drive(2'b00, 2'b00, 12);

        // randomized run-length stimulus
        for (int c = 0; c < N_CH; c++) run[c] = $urandom_range(1, 30);
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                run[c]--;
                if (run[c] == 0) begin
                    pb_raw[c] = ~pb_raw[c];
                    run[c]    = $urandom_range(1, 30);
                end
                if ($urandom_range(0, 7) == 0) repeat_en[c] = ~repeat_en[c];
            end
            rst = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        rst = 1'b0;
        drive(2'b00, 2'b00, 12);

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pb_event_gen.md
Name: pb_event_gen

Overview:
- Multi-channel push-button front end, the parametrised successor of the single-channel one-pulse stage.
- Per channel, it synchronises a raw button input, debounces it with a programmable stable-time filter, and emits single-cycle press and release pulses.
- It also flags long presses and, optionally, generates auto-repeat pulses while a button is held.
- It sits between board pushbuttons and control FSMs (counters, menus, stopwatch controls) in the clk_100 domain.

Parameters:
- N_CH, 4, number of independent button channels (>=1).
- DEB_CYCLES, 20, consecutive cycles the synchronised input must differ from pb_level before pb_level flips (>=1).
- HOLD_CYCLES, 50000000, cycles after press_pulse before long_press asserts (>=1).
- REPEAT_CYCLES, 10000000, spacing in cycles between successive repeat_pulse outputs (>=1).
- CNT_W, 27, width of every internal counter; must hold max(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- clk_100  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pb_raw  input  N_CH  asynchronous raw button levels, 1 = pressed.
- repeat_en  input  N_CH  per-channel auto-repeat enable, sampled every cycle.
- pb_level  output  N_CH  debounced level, registered.
- press_pulse  output  N_CH  one-cycle pulse on a debounced 0->1 transition.
- release_pulse  output  N_CH  one-cycle pulse on a debounced 1->0 transition.
- long_press  output  N_CH  level; high while held beyond HOLD_CYCLES.
- repeat_pulse  output  N_CH  one-cycle auto-repeat pulse.

Behaviour:
- Channels are fully independent; the description below applies per channel i.
- Reset (rst=1 at an edge): sync flops, pb_level, debounce count, hold/repeat counts, FSM state, and all outputs are cleared to 0. Reset overrides every other event.
- Sync stage: two flops s1 <= pb_raw[i], s2 <= s1. Only s2 feeds the filter.
- Debounce:
  - If s2 != pb_level: when cnt == DEB_CYCLES-1, pb_level <= s2 and cnt <= 0; otherwise cnt++.
  - If s2 == pb_level: cnt <= 0. Any glitch shorter than DEB_CYCLES is rejected and restarts the count.
- Latency: pb_raw first sampled high at edge k and held → pb_level and press_pulse rise after edge k+DEB_CYCLES+1. Release latency is identical.
- press_pulse/release_pulse: registered; asserted exactly in the cycle pb_level first shows the new value; high for exactly 1 cycle; never both high together.
- Hold FSM, states RELEASED, HELD, REPEATING:
  - RELEASED: hcnt=0. On the debounced press edge → HELD, hcnt <= 0.
  - HELD: hcnt++ each cycle. When hcnt == HOLD_CYCLES-1 → REPEATING; long_press <= 1; repeat_pulse <= repeat_en[i] in that same cycle; rcnt <= 0.
  - REPEATING: long_press stays 1. rcnt++; when rcnt == REPEAT_CYCLES-1: rcnt <= 0 and repeat_pulse <= repeat_en[i].
  - repeat_en low suppresses pulses only; rcnt keeps running, so re-enabling stays phase-aligned.
  - Any state, debounced release edge → RELEASED; long_press <= 0, repeat_pulse <= 0, counters cleared, in the same cycle as release_pulse.
- Timing from press: long_press rises HOLD_CYCLES cycles after the press_pulse cycle. With repeat_en=1, the first repeat_pulse coincides with long_press rising, and later pulses follow every REPEAT_CYCLES.
- Release in the same edge that hcnt would expire: release wins; no long_press, no repeat_pulse.
- Reset mid-press: all outputs drop to 0 on the reset edge. If pb_raw stays high after reset, a fresh press_pulse appears after the full sync + debounce latency.
- Counters saturate nowhere; CNT_W is sized so they never wrap.

Test Plan:
- Params N_CH=2, DEB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3 for all scenarios.
- Reset then clean press: pb_raw[0] 0→1 sampled at edge 0, held → pb_level[0]=1 and press_pulse[0]=1 only after edge 5; channel 1 outputs stay 0.
- Glitch rejection: pb_raw[0] high for 3 cycles then low → no press_pulse, pb_level stays 0. A 4-cycle-stable high (post-sync) → press_pulse.
- Long press with repeat: repeat_en[0]=1, hold 30 cycles → long_press rises 10 cycles after press_pulse; repeat_pulse at offsets 10, 13, 16, …; release → release_pulse and long_press=0 on the same cycle, with no further repeat_pulse.
- repeat_en gating: toggle repeat_en[0] low during REPEATING → repeat_pulse absent while low. Re-enable → pulses resume on the original 3-cycle grid.
- Simultaneous channels: press both channels on the same edge → identical press_pulse timing on both. Releasing channel 1 mid-hold does not affect channel 0's long_press.
- Reset mid-hold: assert rst while long_press[0]=1 and pb_raw held → all outputs 0 next edge. After rst deasserts, press_pulse[0] reappears 6 edges later.
